// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request a divide; taken only while ready is high
//   dividend, divisor operands, captured on the accepting edge
//   ready             high in IDLE and DONE
//   busy              high while iterating
//   done              one-cycle pulse, results valid
//   quotient          result quotient, held until the next accepted start
//   remainder         result remainder, held until the next accepted start
//   div_by_zero       captured divisor was zero; held like the results
module seq_restoring_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  // The settled partial remainder is always below the divisor, so WIDTH bits
  // hold it; the shifted value used for the trial subtract is WIDTH+1 bits.
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] divisor_q;
  logic             zero_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: shift {P,Q} left, trial-subtract the divisor as
  // a + ~b + 1 over WIDTH+1 bits, keep the difference when its sign is clear.
  always_comb begin
    shifted = {p_q, q_q[WIDTH-1]};
    trial   = shifted + ~{1'b0, divisor_q} + (WIDTH + 1)'(1);
    q_next  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    if (!trial[WIDTH]) begin
      p_next = trial[WIDTH-1:0];
    end else begin
      p_next = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      zero_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StRun;
            p_q         <= '0;
            q_q         <= dividend;
            divisor_q   <= divisor;
            zero_q      <= (divisor == '0);
            div_by_zero <= 1'b0;
            // A zero divisor spends a single RUN cycle, giving it a
            // two-edge latency; the results are forced at the end.
            cnt_q       <= (divisor == '0) ? LastCnt : '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          p_q   <= p_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            cnt_q   <= '0;
            if (zero_q) begin
              // q_q still holds the untouched dividend here.
              quotient    <= '1;
              remainder   <= q_q;
              div_by_zero <= 1'b1;
            end else begin
              quotient  <= q_next;
              remainder <= p_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready = (state_q != StRun);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_seq_restoring_div.sv
module tb_seq_restoring_div;
  localparam int unsigned WIDTH = 32;
  localparam int MaxWait = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             ready, busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  seq_restoring_div #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: edges left until done, and the visible results.
  int               m_left = 0;
  bit               m_done = 1'b0;
  logic [WIDTH-1:0] eq = '0;
  logic [WIDTH-1:0] er = '0;
  bit               edbz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      eq = '0;
      er = '0;
      edbz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (start) begin
        if (divisor == '0) begin
          eq = '1;
          er = dividend;
          edbz = 1'b1;
          m_left = 2 - 1;
        end else begin
          eq = dividend / divisor;
          er = dividend % divisor;
          edbz = 1'b0;
          m_left = WIDTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 64'(ready), 64'(m_left == 0));
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      if (m_left == 0) begin
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("div_by_zero", 64'(div_by_zero), 64'(edbz));
      end else begin
        check("div_by_zero_run", 64'(div_by_zero), 64'd0);
      end
    end
  end

  // Returns with the start edge counted as edge 1.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < MaxWait) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (n >= MaxWait) check("done_timeout", 64'(n), 64'(MaxWait - 1));
  endtask

  task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int n);
    launch(a, b);
    wait_done(1, n);
  endtask

  initial begin
    int n;
    int k;
    logic [WIDTH-1:0] a, b;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);

    do_div(32'd100, 32'd7, n);
    check("t1_latency", 64'(n), 64'd33);
    check("t1_q", 64'(quotient), 64'd14);
    check("t1_r", 64'(remainder), 64'd2);
    check("t1_dbz", 64'(div_by_zero), 64'd0);

    do_div(32'hFFFF_FFFF, 32'd1, n);
    check("t2a_q", 64'(quotient), 64'hFFFF_FFFF);
    check("t2a_r", 64'(remainder), 64'd0);
    do_div(32'hFFFF_FFFF, 32'h8000_0000, n);
    check("t2b_q", 64'(quotient), 64'd1);
    check("t2b_r", 64'(remainder), 64'h7FFF_FFFF);

    do_div(32'd5, 32'd9, n);
    check("t3a_q", 64'(quotient), 64'd0);
    check("t3a_r", 64'(remainder), 64'd5);
    do_div(32'd1234, 32'd0, n);
    check("t3b_latency", 64'(n), 64'd2);
    check("t3b_q", 64'(quotient), 64'hFFFF_FFFF);
    check("t3b_r", 64'(remainder), 64'd1234);
    check("t3b_dbz", 64'(div_by_zero), 64'd1);

    // Start pulse mid-run must be ignored.
    launch(32'd1000, 32'd3);
    n = 1;
    repeat (5) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    n++;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, n);
    check("t4_latency", 64'(n), 64'd33);
    check("t4_q", 64'(quotient), 64'd333);
    check("t4_r", 64'(remainder), 64'd1);
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) k++;
    end
    check("t4_extra_done", 64'(k), 64'd0);

    // Reset aborts a divide in progress.
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", 64'(ready), 64'd1);
    check("t5_done", 64'(done), 64'd0);
    check("t5_q", 64'(quotient), 64'd0);
    check("t5_r", 64'(remainder), 64'd0);
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) k++;
    end
    check("t5_no_done", 64'(k), 64'd0);
    do_div(32'd9, 32'd2, n);
    check("t5_q2", 64'(quotient), 64'd4);
    check("t5_r2", 64'(remainder), 64'd1);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 32'd81;
    divisor  = 32'd9;
    wait_done(1, n);
    check("t6a_latency", 64'(n), 64'd33);
    check("t6a_q", 64'(quotient), 64'd14);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n);
    check("t6b_latency", 64'(n), 64'd33);
    check("t6b_q", 64'(quotient), 64'd9);
    check("t6b_r", 64'(remainder), 64'd0);

    for (int i = 0; i < 1200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = $urandom | 32'h8000_0000;
        2: b = WIDTH'($urandom_range(1, 15));
        3: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_div(a, b, n);
      check("rand_latency", 64'(n), (b == '0) ? 64'd2 : 64'd33);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
